lab_decoder_scan: RTL and testbench

//  Parametrised, registered successor to the 3-to-8 decoder lab block: N-to-2^N decoder

---
 rtl/lab_decoder_scan.sv | 65 ++++++
 tb/tb_lab_decoder_scan.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/lab_decoder_scan.sv
// lab_decoder_scan: registered N-to-2^N decoder with 74LS138-style enable and prescaled scan mode
// SCAN_BOUNCE_EN defined: scan ping-pongs between the end indices instead of wrapping
module lab_decoder_scan #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 24,
    parameter bit ACTIVE_LOW = 1,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             G1,
    input  logic             G2A_n,
    input  logic             G2B_n,
    input  logic [SEL_W-1:0] A,
    input  logic             mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic [OUT_W-1:0] Y,
    output logic [SEL_W-1:0] idx,
    output logic             tick
);
    logic             en, step, move_dn;
    logic [SEL_W-1:0] idx_n;
    logic [DIV_W-1:0] pre, pre_n;

    function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
        return {OUT_W{ACTIVE_LOW}} ^ (OUT_W'(1) << i);
    endfunction

    assign en   = G1 & ~G2A_n & ~G2B_n;
    assign step = en & mode & (pre >= div);

`ifdef SCAN_BOUNCE_EN
    logic dn, dn_n, at_end;
    // reaching an end flips the flag and the same step moves back inward
    always_comb begin
        at_end  = dn ? idx == '0 : idx == '1;
        move_dn = dn ^ at_end;
        dn_n    = (en & ~mode) ? dir : step ? move_dn : dn;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) dn <= 1'b0;
        else dn <= dn_n;
`else
    assign move_dn = dir;
`endif

    always_comb begin
        idx_n = ~en ? idx : ~mode ? A : step ? (move_dn ? idx - SEL_W'(1) : idx + SEL_W'(1)) : idx;
        pre_n = ~en ? pre : (~mode | step) ? '0 : pre + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx  <= '0;
            pre  <= '0;
            tick <= 1'b0;
            Y    <= {OUT_W{ACTIVE_LOW}};
        end else begin
            idx  <= idx_n;
            pre  <= pre_n;
            tick <= step;
            Y    <= en ? dec(idx_n) : {OUT_W{ACTIVE_LOW}};
        end
endmodule

// File: tb/tb_lab_decoder_scan.sv
// tb_lab_decoder_scan: directed and randomized checks of lab_decoder_scan against a behavioural model
module tb_lab_decoder_scan;
    logic       clk = 0, rst = 1, G1 = 0, G2A_n = 1, G2B_n = 1, mode = 0, dir = 0;
    logic [2:0] A = 0;
    logic [3:0] div = 0;
    logic [7:0] Y;
    logic [2:0] idx;
    logic       tick;

    int vectors = 0, miscompares = 0;
    int m_idx = 0, m_pre = 0, m_dn = 0, m_tick = 0;
    logic [7:0] m_y = 8'hFF;

    lab_decoder_scan #(.SEL_W(3), .DIV_W(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .G1(G1), .G2A_n(G2A_n), .G2B_n(G2B_n), .A(A),
        .mode(mode), .dir(dir), .div(div), .Y(Y), .idx(idx), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // next-state of the observable behaviour, from the inputs about to be sampled
    task automatic model();
        if (!(G1 && !G2A_n && !G2B_n)) begin
            m_tick = 0;
            m_y = 8'hFF;
            return;
        end
        m_tick = 0;
        if (!mode) begin
            m_idx = A;
            m_pre = 0;
            m_dn = dir;
        end else if (m_pre >= div) begin
            m_pre = 0;
            m_tick = 1;
`ifdef SCAN_BOUNCE_EN
            if (!m_dn && m_idx == 7) begin m_dn = 1; m_idx = 6; end
            else if (m_dn && m_idx == 0) begin m_dn = 0; m_idx = 1; end
            else m_idx = m_dn ? m_idx - 1 : m_idx + 1;
`else
            m_idx = dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
`endif
        end else m_pre++;
        m_y = 8'hFF ^ (8'd1 << m_idx);
    endtask

    task automatic cyc();
        model();
        @(posedge clk);
        #1;
        chk("Y", Y, m_y);
        chk("idx", idx, m_idx);
        chk("tick", tick, m_tick);
    endtask

    task automatic async_rst();
        #2 rst = 1;
        #1;
        chk("rst_Y", Y, 8'hFF);
        chk("rst_idx", idx, 0);
        chk("rst_tick", tick, 0);
        m_idx = 0; m_pre = 0; m_dn = 0; m_tick = 0; m_y = 8'hFF;
        #2 rst = 0;
    endtask

    int seq_b[4];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_Y", Y, 8'hFF);
        chk("reset_idx", idx, 0);
        chk("reset_tick", tick, 0);
        rst = 0;
        // direct decode
        G1 = 1; G2A_n = 0; G2B_n = 0; mode = 0; A = 5;
        cyc();
        chk("t1_Y", Y, 8'b1101_1111);
        for (int i = 0; i < 8; i++) begin A = 3'(i); cyc(); end
        G2B_n = 1;
        cyc();
        chk("t2_Y", Y, 8'hFF);
        chk("t2_idx", idx, 7);
        G2B_n = 0;
        // scan up with div=2 from 6
        A = 6; cyc();
        mode = 1; dir = 0; div = 2;
        repeat (3) cyc();
        chk("t3_idx7", idx, 7);
        chk("t3_tick", tick, 1);
        repeat (3) cyc();
        chk("t3_Y0", Y, 8'hFE);
        // scan down every clk from 1, then freeze
        mode = 0; A = 1; dir = 1; cyc();
        mode = 1; div = 0;
        repeat (3) cyc();
`ifndef SCAN_BOUNCE_EN
        chk("t4_idx6", idx, 6);
`endif
        G1 = 0;
        repeat (4) cyc();
        chk("t4_frozen_Y", Y, 8'hFF);
        G1 = 1;
        repeat (2) cyc();
        async_rst();
        repeat (3) cyc();
        // end-of-range behaviour from 5 going up
        mode = 0; A = 5; dir = 0; cyc();
        mode = 1; div = 0;
`ifdef SCAN_BOUNCE_EN
        seq_b = '{6, 7, 6, 5};
`else
        seq_b = '{6, 7, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6_seq", idx, seq_b[i]);
        end
        // randomized
        for (int i = 0; i < 600; i++) begin
            G1 = $urandom_range(0, 9) != 0;
            G2A_n = $urandom_range(0, 19) == 0;
            G2B_n = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 9) == 0) div = 4'($urandom_range(0, 5));
            A = 3'($urandom);
            if ($urandom_range(0, 99) == 0) async_rst();
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
